// File: rtl/axis_uart_rx_pkg.sv
// Shared parameters for the AXI-Stream UART blocks.
// Frame: start, DATA_BITS LSB first, one parity bit, STOP_BITS stop bits.
package axis_uart_pkg_prm;
    localparam int unsigned CLOCK          = 50_000_000;
    localparam int unsigned BAUD_RATE      = 115_200;
    localparam int unsigned AXI_DATA_WIDTH = 32;
    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned PARITY_BITS    = 1;
    localparam int unsigned STOP_BITS      = 1;

    // Parity bit the transmitter appends, given the XOR of the data bits.
    function automatic logic parity_bit(input logic data_xor);
        return (PARITY_BITS != 0) ? data_xor : ~data_xor;
    endfunction
endpackage

// File: rtl/axis_uart_rx_if.sv
// AXI-Stream data/valid/ready bundle with master and slave views.
interface axis_if
    import axis_uart_pkg_prm::*;
#(
    parameter int unsigned DATA_W = AXI_DATA_WIDTH
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport m_axis (output tdata, output tvalid, input tready);
    modport s_axis (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus falling-edge detect.
module axis_uart_rx_sync (
    input  logic aclk,
    input  logic areset,
    input  logic din,
    output logic dout,
    output logic fall
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Idle-high reset keeps a released reset from looking like a start edge.
    always_ff @(posedge aclk) begin
        if (areset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign dout = sync_q;
    assign fall = prev_q & ~sync_q;
endmodule

// File: rtl/axis_uart_rx.sv
// UART receiver: samples frames mid-bit, packs bytes MSB-first into a word
// and presents completed words on an AXI-Stream master port.
module axis_uart_rx
    import axis_uart_pkg_prm::*;
#(
    parameter int unsigned CLK_HZ  = CLOCK,
    parameter int unsigned BAUD_HZ = BAUD_RATE
) (
    input  logic   aclk,
    input  logic   areset,
    input  logic   uart_rx,
    output logic   rx_done,
    output logic   parity_err,
    output logic   frame_err,
    output logic   overrun,
    axis_if.m_axis m_axis
);
    localparam int unsigned COUNT_SPEED = CLK_HZ / BAUD_HZ;
    localparam int unsigned DATA_BYTE   = AXI_DATA_WIDTH / DATA_BITS;
    localparam int unsigned BAUD_W      = $clog2(COUNT_SPEED);
    localparam int unsigned BIT_W       = $clog2(((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS) + 1);
    localparam int unsigned BYTE_W      = (DATA_BYTE > 1) ? $clog2(DATA_BYTE) : 1;
    localparam int unsigned IDX_W       = $clog2(AXI_DATA_WIDTH);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } state_type_uart_rx;

    state_type_uart_rx         state_q, state_d;
    logic [BAUD_W-1:0]         count_baud_q, count_baud_d;
    logic [BIT_W-1:0]          count_bit_q, count_bit_d;
    logic [BYTE_W-1:0]         count_byte_q, count_byte_d;
    logic [AXI_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                      par_q, par_d;
    logic                      word_perr_q, word_perr_d;
    logic [AXI_DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                      tvalid_q, tvalid_d;
    logic                      rx_done_q, rx_done_d;
    logic                      parity_err_q, parity_err_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;

    logic             rx_s;
    logic             rx_fall;
    logic             half_tick;
    logic             bit_tick;
    logic [IDX_W-1:0] bit_idx;

    axis_uart_rx_sync u_sync (
        .aclk   (aclk),
        .areset (areset),
        .din    (uart_rx),
        .dout   (rx_s),
        .fall   (rx_fall)
    );

    assign half_tick = (count_baud_q == BAUD_W'(COUNT_SPEED / 2 - 1));
    assign bit_tick  = (count_baud_q == BAUD_W'(COUNT_SPEED - 1));
    // First byte of a word lands in the top DATA_BITS of the shift register.
    assign bit_idx   = IDX_W'(AXI_DATA_WIDTH - (32'(count_byte_q) + 32'd1) * DATA_BITS
                              + 32'(count_bit_q));

    always_comb begin
        state_d      = state_q;
        count_baud_d = count_baud_q + BAUD_W'(1);
        count_bit_d  = count_bit_q;
        count_byte_d = count_byte_q;
        shift_d      = shift_q;
        par_d        = par_q;
        word_perr_d  = word_perr_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q && !m_axis.tready;
        rx_done_d    = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        case (state_q)
            RX_IDLE: begin
                count_baud_d = '0;
                if (rx_fall) state_d = RX_START;
            end
            RX_START: begin
                if (half_tick) begin
                    count_baud_d = '0;
                    count_bit_d  = '0;
                    par_d        = 1'b0;
                    state_d      = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_tick) begin
                    count_baud_d     = '0;
                    shift_d[bit_idx] = rx_s;
                    par_d            = par_q ^ rx_s;
                    if (count_bit_q == BIT_W'(DATA_BITS - 1)) begin
                        count_bit_d = '0;
                        state_d     = RX_PARITY;
                    end else begin
                        count_bit_d = count_bit_q + BIT_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (bit_tick) begin
                    count_baud_d = '0;
                    count_bit_d  = '0;
                    if (rx_s != parity_bit(par_q)) word_perr_d = 1'b1;
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (bit_tick) begin
                    count_baud_d = '0;
                    if (!rx_s) begin
                        frame_err_d  = 1'b1;
                        count_byte_d = '0;
                        word_perr_d  = 1'b0;
                        state_d      = RX_IDLE;
                    end else if (count_bit_q == BIT_W'(STOP_BITS - 1)) begin
                        state_d = RX_IDLE;
                        if (count_byte_q == BYTE_W'(DATA_BYTE - 1)) begin
                            count_byte_d = '0;
                            word_perr_d  = 1'b0;
                            // Load only if the output register is free this cycle.
                            if (!tvalid_q || m_axis.tready) begin
                                tdata_d      = shift_q;
                                tvalid_d     = 1'b1;
                                rx_done_d    = 1'b1;
                                parity_err_d = word_perr_q;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            count_byte_d = count_byte_q + BYTE_W'(1);
                        end
                    end else begin
                        count_bit_d = count_bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d      = RX_IDLE;
                count_baud_d = '0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= RX_IDLE;
            count_baud_q <= '0;
            count_bit_q  <= '0;
            count_byte_q <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            word_perr_q  <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            rx_done_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_baud_q <= count_baud_d;
            count_bit_q  <= count_bit_d;
            count_byte_q <= count_byte_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            word_perr_q  <= word_perr_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            rx_done_q    <= rx_done_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign rx_done       = rx_done_q;
    assign parity_err    = parity_err_q;
    assign frame_err     = frame_err_q;
    assign overrun       = overrun_q;
endmodule
